serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 96 +++++++++
 tb/tb_serial_adder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin, sub,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin, sub,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// one bit per clk. WIDTH legal range is 2..64.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last completed result
// RUN   | one operand bit pair consumed per clock; WIDTH clocks per operation
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;
   logic             ovf_q;
   logic             s_bit;
   logic             carry_nxt;
   logic             last_bit;

   // Full-adder cell on the current LSBs plus the terminal-bit detect.
   always_comb begin
      s_bit     = op_a[0] ^ op_b[0] ^ carry;
      carry_nxt = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
      last_bit  = (cnt == CW'(WIDTH - 1));
   end

   // Sequencer, operand shifters and result registers. On the last bit the carry
   // flop still holds the carry into the MSB, which is what overflow needs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_a   <= '0;
         op_b   <= '0;
         res    <= '0;
         sum_q  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_a   <= bus.a;
                  op_b   <= bus.sub ? ~bus.b : bus.b;
                  carry  <= bus.sub ? 1'b1 : bus.cin;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               res   <= {s_bit, res[WIDTH-1:1]};
               carry <= carry_nxt;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  sum_q  <= {s_bit, res[WIDTH-1:1]};
                  cout_q <= carry_nxt;
                  ovf_q  <= carry ^ carry_nxt;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 5-bit instance, each shadowed by a
// cycle model whose expected results are queued at accept and popped at completion.
module tb_serial_adder;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   serial_adder_if #(.WIDTH(8)) if8 ();
   serial_adder_if #(.WIDTH(5)) if5 ();

   serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_adder #(.WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: {overflow, cout, sum} for a w-bit add or subtract.
   function automatic logic [65:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic cin, input logic sub, input int w);
      logic [63:0] mask;
      logic [63:0] am;
      logic [63:0] bb;
      logic [63:0] s;
      logic [64:0] full;
      logic        c0;
      logic        ovf;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am   = a & mask;
      bb   = (sub ? ~b : b) & mask;
      c0   = sub ? 1'b1 : cin;
      full = {1'b0, am} + {1'b0, bb} + 65'(c0);
      s    = full[63:0] & mask;
      ovf  = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
      return {ovf, full[w], s};
   endfunction

   // Cycle models: queue expected result at accept, publish it on the WIDTH-th RUN edge.
   logic [65:0] q8[$];
   logic [65:0] q5[$];
   logic [65:0] pub8, pub5;
   bit          m8_busy, m8_done, m5_busy, m5_done;
   int          m8_cnt, m5_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m8_busy = 0; m8_done = 0; m8_cnt = 0; pub8 = '0; q8.delete();
      end else begin
         m8_done = 0;
         if (m8_busy) begin
            m8_cnt++;
            if (m8_cnt == 8) begin
               m8_busy = 0;
               m8_done = 1;
               if (q8.size() != 0) pub8 = q8.pop_front();
            end
         end else if (if8.start) begin
            q8.push_back(ref_model(64'(if8.a), 64'(if8.b), if8.cin, if8.sub, 8));
            m8_busy = 1;
            m8_cnt  = 0;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m5_busy = 0; m5_done = 0; m5_cnt = 0; pub5 = '0; q5.delete();
      end else begin
         m5_done = 0;
         if (m5_busy) begin
            m5_cnt++;
            if (m5_cnt == 5) begin
               m5_busy = 0;
               m5_done = 1;
               if (q5.size() != 0) pub5 = q5.pop_front();
            end
         end else if (if5.start) begin
            q5.push_back(ref_model(64'(if5.a), 64'(if5.b), if5.cin, if5.sub, 5));
            m5_busy = 1;
            m5_cnt  = 0;
         end
      end
   end

   // Every cycle out of reset: handshake and result registers against the models.
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy8", 66'(if8.busy), 66'(m8_busy));
         check("done8", 66'(if8.done), 66'(m8_done));
         check("res8", 66'({if8.overflow, if8.cout, if8.sum}), 66'({pub8[65:64], pub8[7:0]}));
         check("busy5", 66'(if5.busy), 66'(m5_busy));
         check("done5", 66'(if5.done), 66'(m5_done));
         check("res5", 66'({if5.overflow, if5.cout, if5.sum}), 66'({pub5[65:64], pub5[4:0]}));
      end
   end

   // Directed 8-bit op issued at a negedge, with fixed expected result and timing.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input logic [7:0] es, input logic ec, input logic eo);
      int lat;
      int bc;
      if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub; if8.start = 1'b1;
      lat = 0;
      bc  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) if8.start = 1'b0;
         if (if8.busy) bc++;
         if (if8.done) begin
            lat = i;
            break;
         end
      end
      check("latency8", 66'(lat), 66'(9));
      check("busy_cycles8", 66'(bc), 66'(8));
      check("directed8", 66'({if8.overflow, if8.cout, if8.sum}), 66'({eo, ec, es}));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      if8.start = 0; if8.a = '0; if8.b = '0; if8.cin = 0; if8.sub = 0;
      if5.start = 0; if5.a = '0; if5.b = '0; if5.cin = 0; if5.sub = 0;
      repeat (2) @(negedge clk);
      check("rst_outs8", 66'({if8.busy, if8.done, if8.overflow, if8.cout, if8.sum}), 66'(0));
      check("rst_outs5", 66'({if5.busy, if5.done, if5.overflow, if5.cout, if5.sum}), 66'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
      run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
      run8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
      run8(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
      run8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
      run8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Asynchronous reset mid-operation, between clock edges, during bit 4.
      if8.a = 8'h0F; if8.b = 8'h0F; if8.cin = 0; if8.sub = 0; if8.start = 1'b1;
      @(posedge clk);
      #1 if8.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst8", 66'({if8.busy, if8.done, if8.overflow, if8.cout, if8.sum}), 66'(0));
      check("async_rst5", 66'({if5.busy, if5.done, if5.overflow, if5.cout, if5.sum}), 66'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

      // start held high with operands changing every cycle.
      dones = 0;
      if8.start = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         if8.a = 8'($urandom); if8.b = 8'($urandom);
         if8.cin = 1'($urandom); if8.sub = 1'($urandom);
         @(negedge clk);
         if (if8.done) dones++;
      end
      if8.start = 1'b0;
      check("b2b_done_count", 66'(dones), 66'(5));
      repeat (12) @(negedge clk);

      // Random operations on both widths.
      for (int n = 0; n < 1000; n++) begin
         if8.a = 8'($urandom); if8.b = 8'($urandom);
         if8.cin = 1'($urandom); if8.sub = 1'($urandom);
         if5.a = 5'($urandom); if5.b = 5'($urandom);
         if5.cin = 1'($urandom); if5.sub = 1'($urandom);
         if8.start = 1'b1;
         if5.start = 1'b1;
         for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
               if8.start = 1'b0;
               if5.start = 1'b0;
            end
            if (if8.done) break;
            if (i == 20) check("rand_timeout8", 66'(0), 66'(1));
         end
      end
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
